alu_ctrl_muldiv: RTL and testbench

Execute-stage ALU control block with an integrated iterative multiply/divide sequencer and the HI/LO register pair. It maps `opcode` to the ALU function code exactly as the existing ALU control does. It also executes MULT/MULTU/DIV/DIVU over multiple cycles, services MTHI/MTLO/MFHI/MFLO, and raises a stall to the pipeline while a long operation is in flight. It sits between the decode outputs and the ALU/register-writeback mux.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/muldiv_iter.sv | 69 ++++++
 rtl/alu_ctrl_muldiv.sv | 192 +++++++++++++++++++
 tb/tb_alu_ctrl_muldiv.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants and the multiply/divide sequencer state type
// for the execute-stage ALU control.
package mips_pkg;

    localparam logic [5:0] OPCODE_RTYPE  = 6'h00;
    localparam logic [5:0] OPCODE_REGIMM = 6'h01;
    localparam logic [5:0] OPCODE_BEQ    = 6'h04;
    localparam logic [5:0] OPCODE_BNE    = 6'h05;
    localparam logic [5:0] OPCODE_BLEZ   = 6'h06;
    localparam logic [5:0] OPCODE_BGTZ   = 6'h07;
    localparam logic [5:0] OPCODE_ADDIU  = 6'h09;
    localparam logic [5:0] OPCODE_SLTI   = 6'h0A;
    localparam logic [5:0] OPCODE_SLTIU  = 6'h0B;
    localparam logic [5:0] OPCODE_ANDI   = 6'h0C;
    localparam logic [5:0] OPCODE_ORI    = 6'h0D;
    localparam logic [5:0] OPCODE_XORI   = 6'h0E;
    localparam logic [5:0] OPCODE_LB     = 6'h20;
    localparam logic [5:0] OPCODE_LH     = 6'h21;
    localparam logic [5:0] OPCODE_LWL    = 6'h22;
    localparam logic [5:0] OPCODE_LW     = 6'h23;
    localparam logic [5:0] OPCODE_LBU    = 6'h24;
    localparam logic [5:0] OPCODE_LHU    = 6'h25;
    localparam logic [5:0] OPCODE_LWR    = 6'h26;
    localparam logic [5:0] OPCODE_SB     = 6'h28;
    localparam logic [5:0] OPCODE_SH     = 6'h29;
    localparam logic [5:0] OPCODE_SWL    = 6'h2A;
    localparam logic [5:0] OPCODE_SW     = 6'h2B;
    localparam logic [5:0] OPCODE_SWR    = 6'h2E;

    localparam logic [5:0] FUNCT_MFHI    = 6'h10;
    localparam logic [5:0] FUNCT_MTHI    = 6'h11;
    localparam logic [5:0] FUNCT_MFLO    = 6'h12;
    localparam logic [5:0] FUNCT_MTLO    = 6'h13;
    localparam logic [5:0] FUNCT_MULT    = 6'h18;
    localparam logic [5:0] FUNCT_MULTU   = 6'h19;
    localparam logic [5:0] FUNCT_DIV     = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU    = 6'h1B;
    localparam logic [5:0] FUNCT_ADDU    = 6'h21;
    localparam logic [5:0] FUNCT_AND     = 6'h24;
    localparam logic [5:0] FUNCT_OR      = 6'h25;
    localparam logic [5:0] FUNCT_XOR     = 6'h26;
    localparam logic [5:0] FUNCT_SLT     = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU    = 6'h2B;
    localparam logic [5:0] FUNCT_INVALID = 6'h3F;

    typedef enum logic [1:0] {IDLE, RUN, FIX, ZDIV} muldiv_state_t;

    function automatic logic is_hilo_funct(input logic [5:0] f);
        case (f)
            FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: shift-add multiply (acc:sreg = product) and restoring
// divide (sreg = quotient, acc = remainder), one step per enabled cycle.
module muldiv_iter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] sreg
);

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;
    logic [WIDTH-1:0] acc_nx_s;
    logic [WIDTH-1:0] sreg_nx_s;

    // Next-step value for either algorithm; the trial remainder is W+1 bits
    // wide but any successful subtraction result fits back into W bits.
    always_comb begin
        sum_s     = {1'b0, acc_r} + (sreg_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        ge_s      = ({acc_r, sreg_r[WIDTH-1]} >= {1'b0, opb_r});
        diff_s    = {acc_r[WIDTH-2:0], sreg_r[WIDTH-1]} - opb_r;
        acc_nx_s  = acc_r;
        sreg_nx_s = sreg_r;
        if (is_div) begin
            if (ge_s) begin
                acc_nx_s  = diff_s;
                sreg_nx_s = {sreg_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx_s  = {acc_r[WIDTH-2:0], sreg_r[WIDTH-1]};
                sreg_nx_s = {sreg_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nx_s  = sum_s[WIDTH:1];
            sreg_nx_s = {sum_s[0], sreg_r[WIDTH-1:1]};
        end
    end

    // Operand load and per-cycle step registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {WIDTH{1'b0}};
            sreg_r <= {WIDTH{1'b0}};
            opb_r  <= {WIDTH{1'b0}};
        end else if (load) begin
            acc_r  <= {WIDTH{1'b0}};
            sreg_r <= a_in;
            opb_r  <= b_in;
        end else if (step) begin
            acc_r  <= acc_nx_s;
            sreg_r <= sreg_nx_s;
        end
    end

    assign acc  = acc_r;
    assign sreg = sreg_r;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// Execute-stage ALU control: opcode-to-function decode plus the HI/LO pair and
// the multi-cycle multiply/divide sequencer with its pipeline stall.
module alu_ctrl_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FN_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [5:0]       opcode,
    input  logic [FN_W-1:0]  rtype_fncode,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [FN_W-1:0]  fncode,
    output logic             busy_o,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);

    muldiv_state_t      state_r, state_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               is_div_r, signed_r, neg_a_r, neg_b_r;
    logic [WIDTH-1:0]   hi_r, lo_r, hi_nx_s, lo_nx_s;
    logic [5:0]         funct_s;
    logic               is_rtype_s, accept_s, is_mul_s, is_divop_s, sgn_s, start_s, zdiv_s;
    logic               load_s, step_s;
    logic [WIDTH-1:0]   a_in_s, b_in_s, acc_s, sreg_s;
    logic [2*WIDTH-1:0] prod_s;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign funct_s    = rtype_fncode[5:0];
    assign is_rtype_s = (opcode == OPCODE_RTYPE);
    assign is_mul_s   = (funct_s == FUNCT_MULT) || (funct_s == FUNCT_MULTU);
    assign is_divop_s = (funct_s == FUNCT_DIV)  || (funct_s == FUNCT_DIVU);
    assign sgn_s      = (funct_s == FUNCT_MULT) || (funct_s == FUNCT_DIV);
    assign accept_s   = valid_i && (state_r == IDLE);
    assign start_s    = accept_s && is_rtype_s && (is_mul_s || is_divop_s);
    assign zdiv_s     = is_divop_s && (rt_val == {WIDTH{1'b0}});
    assign busy_o     = (state_r != IDLE);
    assign stall_o    = valid_i && is_rtype_s && is_hilo_funct(funct_s) && busy_o;
    assign hi_o       = hi_r;
    assign lo_o       = lo_r;

    // Divide-by-zero keeps the raw dividend so it can be copied into HI.
    assign a_in_s = zdiv_s ? rs_val : mag(rs_val, sgn_s && rs_val[WIDTH-1]);
    assign b_in_s = mag(rt_val, sgn_s && rt_val[WIDTH-1]);

    // Opcode to ALU function code, independent of valid and sequencer state.
    always_comb begin
        fncode = FN_W'(FUNCT_INVALID);
        case (opcode)
            OPCODE_ADDIU, OPCODE_BEQ, OPCODE_BNE, OPCODE_BGTZ, OPCODE_BLEZ, OPCODE_REGIMM,
            OPCODE_LB, OPCODE_LH, OPCODE_LWL, OPCODE_LW, OPCODE_LBU, OPCODE_LHU, OPCODE_LWR,
            OPCODE_SB, OPCODE_SH, OPCODE_SWL, OPCODE_SW, OPCODE_SWR:
                          fncode = FN_W'(FUNCT_ADDU);
            OPCODE_ANDI:  fncode = FN_W'(FUNCT_AND);
            OPCODE_ORI:   fncode = FN_W'(FUNCT_OR);
            OPCODE_XORI:  fncode = FN_W'(FUNCT_XOR);
            OPCODE_SLTI:  fncode = FN_W'(FUNCT_SLT);
            OPCODE_SLTIU: fncode = FN_W'(FUNCT_SLTU);
            OPCODE_RTYPE: fncode = rtype_fncode;
            default:      fncode = FN_W'(FUNCT_INVALID);
        endcase
    end

    // Sequencer next state and datapath controls.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    load_s     = 1'b1;
                    state_nx_s = zdiv_s ? ZDIV : RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nx_s = FIX;
                end else begin
                    state_nx_s = RUN;
                end
            end
            FIX:     state_nx_s = IDLE;
            ZDIV:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Iteration counter and captured operation/sign flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= 1'b0;
            signed_r <= 1'b0;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
        end else if (load_s) begin
            cnt_r    <= CNT_W'(WIDTH - 1);
            is_div_r <= is_divop_s;
            signed_r <= sgn_s;
            neg_a_r  <= rs_val[WIDTH-1];
            neg_b_r  <= rt_val[WIDTH-1];
        end else if (step_s) begin
            cnt_r    <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_s),
        .step   (step_s),
        .is_div (is_div_r),
        .a_in   (a_in_s),
        .b_in   (b_in_s),
        .acc    (acc_s),
        .sreg   (sreg_s)
    );

    // HI/LO update: moves on acceptance, sign-fixed results at FIX, div-by-zero result at ZDIV.
    always_comb begin
        hi_nx_s = hi_r;
        lo_nx_s = lo_r;
        prod_s  = {acc_s, sreg_s};
        if (signed_r && (neg_a_r ^ neg_b_r)) begin
            prod_s = -prod_s;
        end else begin
            prod_s = {acc_s, sreg_s};
        end
        case (state_r)
            IDLE: begin
                if (accept_s && is_rtype_s && (funct_s == FUNCT_MTHI)) begin
                    hi_nx_s = rs_val;
                end else if (accept_s && is_rtype_s && (funct_s == FUNCT_MTLO)) begin
                    lo_nx_s = rs_val;
                end else begin
                    hi_nx_s = hi_r;
                end
            end
            FIX: begin
                if (is_div_r) begin
                    hi_nx_s = (signed_r && neg_a_r) ? -acc_s : acc_s;
                    lo_nx_s = (signed_r && (neg_a_r ^ neg_b_r)) ? -sreg_s : sreg_s;
                end else begin
                    hi_nx_s = prod_s[2*WIDTH-1:WIDTH];
                    lo_nx_s = prod_s[WIDTH-1:0];
                end
            end
            ZDIV: begin
                hi_nx_s = sreg_s;
                lo_nx_s = {WIDTH{1'b1}};
            end
            default: begin
                hi_nx_s = hi_r;
            end
        endcase
    end

    // HI/LO register pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else begin
            hi_r <= hi_nx_s;
            lo_r <= lo_nx_s;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Scoreboard bench for alu_ctrl_muldiv: directed vectors push expected HI/LO and
// busy length; a monitor pops and compares when busy_o falls.
module tb_alu_ctrl_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [5:0]  opcode;
    logic [5:0]  rtype_fncode;
    logic [31:0] rs_val, rt_val;
    logic [5:0]  fncode;
    logic        busy_o, stall_o;
    logic [31:0] hi_o, lo_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;
    exp_t exp_q[$];

    alu_ctrl_muldiv #(.WIDTH(32), .FN_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .opcode       (opcode),
        .rtype_fncode (rtype_fncode),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .fncode       (fncode),
        .busy_o       (busy_o),
        .stall_o      (stall_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles, compare HI/LO with the scoreboard when busy falls.
    initial begin
        int   busy_cnt;
        logic busy_prev;
        exp_t e;
        busy_cnt  = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt  = 0;
                busy_prev = 1'b0;
            end else begin
                if (busy_o) begin
                    busy_cnt++;
                end else if (busy_prev) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_hi"}, {32'd0, hi_o}, {32'd0, e.hi});
                        check({e.name, "_lo"}, {32'd0, lo_o}, {32'd0, e.lo});
                        check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.cycles));
                    end
                    busy_cnt = 0;
                end
                busy_prev = busy_o;
            end
        end
    end

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (busy_o && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (busy_o) check({name, "_timeout"}, 64'd1, 64'd0);
        @(negedge clk);
    endtask

    task automatic run_op(input string name, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int cyc);
        exp_q.push_back('{name, ehi, elo, cyc});
        @(negedge clk);
        valid_i = 1'b1; opcode = 6'h00; rtype_fncode = fn; rs_val = a; rt_val = b;
        @(negedge clk);
        valid_i = 1'b0;
        wait_idle(name);
    endtask

    task automatic dec(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic [5:0] exp);
        opcode = op; rtype_fncode = fn;
        #1;
        check(name, {58'd0, fncode}, {58'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int scnt;
        rst_n = 1'b0; valid_i = 1'b0; opcode = 6'h00; rtype_fncode = 6'h00;
        rs_val = 32'd0; rt_val = 32'd0;
        #2;
        check("reset_busy",  {63'd0, busy_o},  64'd0);
        check("reset_stall", {63'd0, stall_o}, 64'd0);
        check("reset_hi",    {32'd0, hi_o},    64'd0);
        check("reset_lo",    {32'd0, lo_o},    64'd0);
        @(negedge clk); #3; rst_n = 1'b1;

        dec("dec_addiu", 6'h09, 6'h00, 6'h21);
        dec("dec_andi",  6'h0C, 6'h00, 6'h24);
        dec("dec_rtype", 6'h00, 6'h2A, 6'h2A);
        dec("dec_other", 6'h3E, 6'h00, 6'h3F);
        dec("dec_lw",    6'h23, 6'h00, 6'h21);
        dec("dec_sltiu", 6'h0B, 6'h00, 6'h2B);
        dec("dec_regimm",6'h01, 6'h00, 6'h21);
        dec("dec_xori",  6'h0E, 6'h00, 6'h26);

        run_op("mult_neg",   6'h18, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 33);
        run_op("multu_max",  6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
        run_op("mult_negneg",6'h18, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 33);
        run_op("div_neg",    6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_op("div_negdiv", 6'h1A, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
        run_op("div_minint", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
        run_op("divu_zero",  6'h1B, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1);
        run_op("div_zero",   6'h1A, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1);

        // MFLO one cycle behind an accepted MULT must stall for the whole busy window.
        exp_q.push_back('{"mult_stall", 32'd0, 32'd30, 33});
        @(negedge clk);
        valid_i = 1'b1; opcode = 6'h00; rtype_fncode = 6'h18; rs_val = 32'd5; rt_val = 32'd6;
        @(negedge clk);
        rtype_fncode = 6'h12; rs_val = 32'd0; rt_val = 32'd0;
        #1;
        scnt = 0;
        while (stall_o && scnt < 100) begin
            scnt++;
            @(negedge clk); #1;
        end
        check("mflo_stall_cycles", 64'(scnt), 64'd33);
        check("mflo_stall_release", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);

        // MTLO and MTHI while idle update at the accepting edge with no stall.
        valid_i = 1'b1; rtype_fncode = 6'h13; rs_val = 32'h1234;
        #1;
        check("mtlo_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        check("mtlo_lo", {32'd0, lo_o}, 64'h1234);
        rtype_fncode = 6'h11; rs_val = 32'hCAFE0001;
        @(negedge clk);
        check("mthi_hi", {32'd0, hi_o}, 64'hCAFE0001);
        rtype_fncode = 6'h10; rs_val = 32'h0;
        @(negedge clk);
        check("mfhi_keeps_hi", {32'd0, hi_o}, 64'hCAFE0001);
        check("mfhi_keeps_lo", {32'd0, lo_o}, 64'h1234);
        valid_i = 1'b0; rtype_fncode = 6'h13; rs_val = 32'h5555;
        @(negedge clk);
        check("mtlo_invalid_ignored", {32'd0, lo_o}, 64'h1234);

        // Reset mid-MULT aborts with no HI/LO update.
        valid_i = 1'b1; rtype_fncode = 6'h18; rs_val = 32'h12345678; rt_val = 32'h9ABCDEF0;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (10) @(negedge clk);
        #2; rst_n = 1'b0; #1;
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_hi",   {32'd0, hi_o},   64'd0);
        check("abort_lo",   {32'd0, lo_o},   64'd0);
        @(negedge clk); #3; rst_n = 1'b1;
        run_op("divu_after_reset", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
